uart_rx_oversample: RTL and testbench

UART receiver that sits directly downstream of the UART transmitter and consumes its serial `line` output. It oversamples the line at 16x the baud rate, validates the start bit, and deserialises 8N1 frames LSB-first. Each received byte is held in an output register with a valid/ready handshake toward the memory-write side. It reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_oversample.sv | 121 ++++++++++++
 tb/tb_uart_rx_oversample.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: 16x oversampling, centre-of-bit sampling, valid/ready output register
// and single-cycle framing/overrun error pulses.
module uart_rx_oversample #(
    parameter int unsigned DIV        = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_line,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]       TICK_CENTRE = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       TICK_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, next_state;
    logic                 sync1, sync2, sync_prev;
    logic                 fell, edge_pend, start_edge;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [3:0]           tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample, shift_en, clear_cnt, load, frame_set, overrun_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_line;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_comb begin
        fell       = sync_prev & ~sync2;
        start_edge = fell | edge_pend;
        tick       = (state != IDLE) && (div_cnt == DIV_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start_edge) next_state = START;
            START: if (sample) next_state = sync2 ? IDLE : DATA;
            DATA:  if (sample && bit_cnt == BIT_LAST) next_state = STOP;
            STOP:  if (sample) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        sample      = tick && (((state == START) && (tick_cnt == TICK_CENTRE)) ||
                               (((state == DATA) || (state == STOP)) && (tick_cnt == TICK_LAST)));
        shift_en    = sample && (state == DATA);
        clear_cnt   = (state == IDLE) && start_edge;
        load        = sample && (state == STOP) && sync2 && (!rx_valid || rx_ready);
        overrun_set = sample && (state == STOP) && sync2 && rx_valid && !rx_ready;
        frame_set   = sample && (state == STOP) && !sync2;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_pend   <= 1'b0;
            div_cnt     <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // An edge seen while leaving a frame is remembered for the first IDLE cycle.
            edge_pend <= fell && (state != IDLE) && (next_state == IDLE);

            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;

            if (clear_cnt || (sample && state == START)) tick_cnt <= '0;
            else if (tick)                               tick_cnt <= tick_cnt + 1'b1;

            if (clear_cnt)     bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};

            if (load) rx_data <= shift_reg;

            if (load)          rx_valid <= 1'b1;
            else if (rx_ready) rx_valid <= 1'b0;

            frame_err   <= frame_set;
            overrun_err <= overrun_set;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample (DIV=4, 64 clocks per bit): scoreboard queue of
// expected bytes, a table of single frames, and hand-written multi-cycle corner cases.
module tb_uart_rx_oversample;
    localparam int unsigned BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, busy;

    uart_rx_oversample #(.DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_line(rx_line), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int fe_cnt = 0, oe_cnt = 0, acc_cnt = 0;
    logic busy_seen = 1'b0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned gap;
        int          exp_fe;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard on every accepted byte, count error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (busy) busy_seen = 1'b1;
            if (frame_err) fe_cnt++;
            if (overrun_err) oe_cnt++;
            if (prev_valid && !prev_ready && rx_valid)
                check("data_hold", 32'(rx_data), 32'(prev_data));
            if (rx_valid && rx_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) check("unexpected_byte", 32'(rx_data), 32'hDEAD);
                else check("rx_data_accept", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        clocks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            clocks(BIT_CLKS);
        end
        rx_line = stop;
        clocks(BIT_CLKS);
    endtask

    initial begin
        int t0, fe0, oe0, acc0;
        vecs[0] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_fe: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, gap: 0,  exp_fe: 0};
        vecs[2] = '{data: 8'h81, stop: 1'b0, gap: 64, exp_fe: 1};
        vecs[3] = '{data: 8'h55, stop: 1'b1, gap: 0,  exp_fe: 0};
        vecs[4] = '{data: 8'h7E, stop: 1'b1, gap: 0,  exp_fe: 0};

        clocks(2);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun_err", 32'(overrun_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        clocks(5);

        // Frame 0xA5, consumer not ready; valid appears 2 (sync) + 609 clocks after the line drops.
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        check("a5_valid_latency", 32'(rise_cyc - t0), 32'd611);
        check("a5_valid", 32'(rx_valid), 32'h1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_no_fe", 32'(fe_cnt), 32'h0);
        check("a5_no_oe", 32'(oe_cnt), 32'h0);
        rx_ready = 1'b1;
        clocks(1);
        rx_ready = 1'b0;
        check("a5_valid_cleared", 32'(rx_valid), 32'h0);
        clocks(20);

        // Short low glitch: false start.
        busy_seen = 1'b0;
        fe0 = fe_cnt; oe0 = oe_cnt;
        rx_line = 1'b0;
        clocks(16);
        rx_line = 1'b1;
        clocks(100);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_idle", 32'(busy), 32'h0);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        check("glitch_no_err", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'h0);

        // Stop bit low, then break: exactly one framing error.
        fe0 = fe_cnt;
        send(8'h3C, 1'b0);
        check("fe_one_pulse", 32'(fe_cnt - fe0), 32'h1);
        clocks(1000);
        check("break_no_more_fe", 32'(fe_cnt - fe0), 32'h1);
        check("break_no_valid", 32'(rx_valid), 32'h0);
        check("break_busy_idle", 32'(busy), 32'h0);
        rx_line = 1'b1;
        clocks(100);

        // Overrun: second byte arrives while the first is unaccepted.
        oe0 = oe_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_one_pulse", 32'(oe_cnt - oe0), 32'h1);
        check("ovr_no_fe", 32'(fe_cnt - fe0), 32'h0);
        rx_ready = 1'b1;
        clocks(1);
        check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
        clocks(20);

        // Table-driven frames, consumer always ready.
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt; oe0 = oe_cnt;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send(vecs[i].data, vecs[i].stop);
            if (vecs[i].gap != 0) begin
                rx_line = 1'b1;
                clocks(int'(vecs[i].gap));
            end
            check("vec_fe", 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            check("vec_oe", 32'(oe_cnt - oe0), 32'h0);
        end
        clocks(5);
        check("vec_accepted", 32'(acc_cnt - acc0), 32'd4);
        check("vec_queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of the data bits of 0x5A.
        rx_line = 1'b0;
        clocks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx_line = (8'h5A >> i) & 8'h01;
            clocks(BIT_CLKS);
        end
        rx_line = 1'b1;
        clocks(20);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        check("mid_rst_rx_data", 32'(rx_data), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_overrun_err", 32'(overrun_err), 32'h0);
        clocks(200);
        acc0 = acc_cnt; fe0 = fe_cnt; oe0 = oe_cnt;
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1);
        clocks(10);
        check("post_rst_accepted", 32'(acc_cnt - acc0), 32'h1);
        check("post_rst_no_err", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'h0);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
